// File: rtl/mbtrain_pkg.sv
// Shared MBTRAIN sideband definitions: message codes and the RX-cal initiator state encoding.
package mbtrain_pkg;

    localparam logic [3:0] SB_NONE       = 4'b0000;
    localparam logic [3:0] SB_START_REQ  = 4'b0001;
    localparam logic [3:0] SB_START_RESP = 4'b0010;
    localparam logic [3:0] SB_END_REQ    = 4'b0011;
    localparam logic [3:0] SB_END_RESP   = 4'b0100;

    typedef enum logic [2:0] {
        StIdle,
        StSendStartReq,
        StWaitStartResp,
        StCalAlgo,
        StSendEndReq,
        StWaitEndResp,
        StTestFinished
    } rx_cal_tx_state_e;

endpackage

// File: rtl/mbtrain_sb_valid_ctrl.sv
// Sideband TX valid handshake: pending request, valid register and valid falling-edge detect.
// Shared by the initiator and responder sides of the sideband TX mux.
module mbtrain_sb_valid_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_blocker,
    input  logic i_busy_negedge,
    input  logic i_clear,
    output logic o_valid,
    output logic o_valid_fall
);

    logic r_pending;
    logic r_valid;
    logic r_valid_dly;
    logic w_pending_next;
    logic w_valid_next;

    // Busy completion beats a fresh request so a just-sent message is never re-sent.
    always_comb begin
        w_pending_next = r_pending;
        w_valid_next   = r_valid;
        if (i_clear) begin
            w_pending_next = 1'b0;
            w_valid_next   = 1'b0;
        end else if (i_busy_negedge && r_valid) begin
            w_pending_next = 1'b0;
            w_valid_next   = 1'b0;
        end else begin
            if (i_req) begin
                w_pending_next = 1'b1;
            end
            if ((i_req || r_pending) && !i_blocker) begin
                w_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_pending   <= 1'b0;
            r_valid     <= 1'b0;
            r_valid_dly <= 1'b0;
        end else begin
            r_pending   <= w_pending_next;
            r_valid     <= w_valid_next;
            r_valid_dly <= r_valid;
        end
    end

    assign o_valid      = r_valid;
    assign o_valid_fall = r_valid_dly && !r_valid;

endmodule

// File: rtl/rx_cal_tx.sv
// MBTRAIN RX-calibration initiator: start req/resp, fixed calibration window, end req/resp, ack.
// Define RX_CAL_TX_TIMEOUT_EN to add the response-wait timeout (o_timeout otherwise tied 0).
module rx_cal_tx #(
    parameter int unsigned CAL_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [3:0] i_decoded_sideband_message,
    input  logic       i_busy_negedge_detected,
    input  logic       i_valid_rx,
    output logic [3:0] o_sideband_message,
    output logic       o_valid_tx,
    output logic       o_test_ack,
    output logic       o_timeout
);
    import mbtrain_pkg::*;

    rx_cal_tx_state_e r_state;
    rx_cal_tx_state_e w_state_next;
    logic [3:0]       r_msg;
    logic [3:0]       w_msg_next;
    logic             r_test_ack;
    logic             w_test_ack_next;
    logic [15:0]      r_cal_cnt;
    logic             w_abort;
    logic             w_cal_done;
    logic             w_req;
    logic             w_resp_match;
    logic             w_timeout_hit;
    logic             w_valid_fall;

    assign w_abort      = (r_state != StIdle) && !i_en;
    assign w_cal_done   = (r_state == StCalAlgo) && (r_cal_cnt == 16'(CAL_CYCLES - 1));
    assign w_req        = i_en && ((r_state == StIdle) || w_cal_done);
    assign w_resp_match =
        ((r_state == StWaitStartResp) && (i_decoded_sideband_message == SB_START_RESP)) ||
        ((r_state == StWaitEndResp)   && (i_decoded_sideband_message == SB_END_RESP));

    mbtrain_sb_valid_ctrl u_valid_ctrl (
        .clk            (clk),
        .rst            (rst),
        .i_req          (w_req),
        .i_blocker      (i_valid_rx),
        .i_busy_negedge (i_busy_negedge_detected),
        .i_clear        (w_abort),
        .o_valid        (o_valid_tx),
        .o_valid_fall   (w_valid_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_msg      <= SB_NONE;
            r_test_ack <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_msg      <= w_msg_next;
            r_test_ack <= w_test_ack_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle:          if (i_en) w_state_next = StSendStartReq;
                StSendStartReq:  if (w_valid_fall) w_state_next = StWaitStartResp;
                StWaitStartResp: begin
                    if (w_resp_match)       w_state_next = StCalAlgo;
                    else if (w_timeout_hit) w_state_next = StTestFinished;
                end
                StCalAlgo:       if (w_cal_done) w_state_next = StSendEndReq;
                StSendEndReq:    if (w_valid_fall) w_state_next = StWaitEndResp;
                StWaitEndResp:   if (w_resp_match || w_timeout_hit) w_state_next = StTestFinished;
                StTestFinished:  w_state_next = StTestFinished;
                default:         w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        w_msg_next      = r_msg;
        w_test_ack_next = r_test_ack;
        if (w_abort) begin
            w_msg_next      = SB_NONE;
            w_test_ack_next = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_msg_next      = i_en ? SB_START_REQ : SB_NONE;
                    w_test_ack_next = 1'b0;
                end
                StWaitStartResp: begin
                    if (!w_resp_match && w_timeout_hit) begin
                        w_msg_next      = SB_NONE;
                        w_test_ack_next = 1'b1;
                    end
                end
                StCalAlgo: if (w_cal_done) w_msg_next = SB_END_REQ;
                StWaitEndResp: begin
                    if (w_resp_match || w_timeout_hit) begin
                        w_msg_next      = SB_NONE;
                        w_test_ack_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Cleared on entry to CAL_ALGO so the window is exactly CAL_CYCLES long.
    always_ff @(posedge clk) begin
        if (rst || (r_state != StCalAlgo) || (w_state_next != StCalAlgo)) begin
            r_cal_cnt <= '0;
        end else begin
            r_cal_cnt <= r_cal_cnt + 16'd1;
        end
    end

`ifdef RX_CAL_TX_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WaitW-1:0] r_wait_cnt;
    logic             r_timeout;
    logic             w_in_wait;

    assign w_in_wait     = (r_state == StWaitStartResp) || (r_state == StWaitEndResp);
    assign w_timeout_hit = w_in_wait && (r_wait_cnt == WaitW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !w_in_wait || (w_state_next != r_state)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + WaitW'(1);
        end
    end

    // A response landing on the timeout edge wins, so the flag stays low then.
    always_ff @(posedge clk) begin
        if (rst || w_abort || (r_state == StIdle)) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit && !w_resp_match) begin
            r_timeout <= 1'b1;
        end
    end

    assign o_timeout = r_timeout;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign w_timeout_hit        = 1'b0;
    assign o_timeout            = 1'b0;
`endif

    assign o_sideband_message = r_msg;
    assign o_test_ack         = r_test_ack;

endmodule

// File: tb/tb_rx_cal_tx.sv
// Directed bench for rx_cal_tx (CAL_CYCLES=4, TIMEOUT_CYCLES=8); timeout cases need
// RX_CAL_TX_TIMEOUT_EN, otherwise the indefinite-wait behaviour is checked instead.
module tb_rx_cal_tx;

    localparam int unsigned CalCycles     = 4;
    localparam int unsigned TimeoutCycles = 8;

    logic       clk;
    logic       rst;
    logic       i_en;
    logic [3:0] i_msg;
    logic       i_busy;
    logic       i_vrx;
    logic [3:0] o_msg;
    logic       o_valid;
    logic       o_ack;
    logic       o_to;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       en;
        logic [3:0] sb;
        logic       busy;
        logic       vrx;
        logic [3:0] exp_msg;
        logic       exp_v;
        logic       exp_ack;
        logic       exp_to;
    } vec_t;

    vec_t vecs[$];

    rx_cal_tx #(
        .CAL_CYCLES     (CalCycles),
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .i_en                       (i_en),
        .i_decoded_sideband_message (i_msg),
        .i_busy_negedge_detected    (i_busy),
        .i_valid_rx                 (i_vrx),
        .o_sideband_message         (o_msg),
        .o_valid_tx                 (o_valid),
        .o_test_ack                 (o_ack),
        .o_timeout                  (o_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic en, input logic [3:0] sb, input logic busy,
                        input logic vrx);
        i_en   = en;
        i_msg  = sb;
        i_busy = busy;
        i_vrx  = vrx;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] em, input logic ev,
                         input logic ea, input logic et);
        n_checks++;
        if (o_msg !== em || o_valid !== ev || o_ack !== ea || o_to !== et) begin
            n_fail++;
            $display("FAIL %s: got msg=%b valid=%b ack=%b timeout=%b, want msg=%b valid=%b ack=%b timeout=%b",
                     name, o_msg, o_valid, o_ack, o_to, em, ev, ea, et);
        end
    endtask

    task automatic add(input logic en, input logic [3:0] sb, input logic busy, input logic vrx,
                       input logic [3:0] em, input logic ev, input logic ea, input logic et);
        vec_t v;
        v.en = en; v.sb = sb; v.busy = busy; v.vrx = vrx;
        v.exp_msg = em; v.exp_v = ev; v.exp_ack = ea; v.exp_to = et;
        vecs.push_back(v);
    endtask

    // From IDLE: request, busy completes, then the FSM sits in WAIT_START_RESP.
    task automatic reach_wait_start(input string tag);
        step(1'b1, 4'h0, 1'b0, 1'b0); check({tag, "_req"},   4'h1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b1, 1'b0); check({tag, "_busy"},  4'h1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b0, 1'b0); check({tag, "_wait"},  4'h1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Happy path, one row per clock.
        add(0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
        add(1, 4'h0, 0, 0, 4'h1, 1, 0, 0);
        add(1, 4'h0, 0, 0, 4'h1, 1, 0, 0);
        add(1, 4'h0, 0, 0, 4'h1, 1, 0, 0);
        add(1, 4'h0, 1, 0, 4'h1, 0, 0, 0);
        add(1, 4'h0, 0, 0, 4'h1, 0, 0, 0);
        add(1, 4'h2, 0, 0, 4'h1, 0, 0, 0);
        add(1, 4'h0, 1, 0, 4'h1, 0, 0, 0);
        add(1, 4'h0, 0, 0, 4'h1, 0, 0, 0);
        add(1, 4'h0, 0, 0, 4'h1, 0, 0, 0);
        add(1, 4'h0, 0, 0, 4'h3, 1, 0, 0);
        add(1, 4'h0, 0, 0, 4'h3, 1, 0, 0);
        add(1, 4'h0, 1, 0, 4'h3, 0, 0, 0);
        add(1, 4'h0, 0, 0, 4'h3, 0, 0, 0);
        add(1, 4'h4, 0, 0, 4'h0, 0, 1, 0);
        add(1, 4'h0, 0, 0, 4'h0, 0, 1, 0);
        add(0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
        add(0, 4'h0, 0, 0, 4'h0, 0, 0, 0);

        rst = 1'b1;
        step(1'b1, 4'h2, 1'b0, 1'b0);
        check("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].sb, vecs[i].busy, vecs[i].vrx);
            check($sformatf("vec%0d", i), vecs[i].exp_msg, vecs[i].exp_v,
                  vecs[i].exp_ack, vecs[i].exp_to);
        end

        // Mux contention: responder owns the sideband for 5 cycles.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 4'h0, 1'b0, 1'b1);
            check($sformatf("contend%0d", k), 4'h1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 4'h0, 1'b0, 1'b0); check("contend_release", 4'h1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b1, 1'b0); check("contend_busy",    4'h1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0); check("contend_abort",   4'h0, 1'b0, 1'b0, 1'b0);

        // Abort from CAL_ALGO, then restart from the start request.
        reach_wait_start("abort");
        step(1'b1, 4'h2, 1'b0, 1'b0); check("abort_cal",   4'h1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b0, 1'b0); check("abort_cal1",  4'h1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0); check("abort_drop",  4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0); check("abort_idle",  4'h0, 1'b0, 1'b0, 1'b0);

        // Restart, then a wrong code in WAIT_START_RESP must be ignored.
        reach_wait_start("restart");
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 4'h4, 1'b0, 1'b0);
            check($sformatf("wrongmsg%0d", k), 4'h1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 4'h2, 1'b0, 1'b0); check("late_resp", 4'h1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'h0, 1'b0, 1'b0);
            check($sformatf("late_cal%0d", k), 4'h1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 4'h0, 1'b0, 1'b0); check("late_endreq", 4'h3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b1, 1'b0); check("late_busy",   4'h3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b0, 1'b0); check("late_wait",   4'h3, 1'b0, 1'b0, 1'b0);

        // Synchronous reset while waiting for the end response.
        step(1'b1, 4'h0, 1'b0, 1'b0); check("pre_rst", 4'h3, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 4'h4, 1'b0, 1'b0); check("mid_rst", 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 4'h0, 1'b0, 1'b0); check("post_rst", 4'h0, 1'b0, 1'b0, 1'b0);

`ifdef RX_CAL_TX_TIMEOUT_EN
        reach_wait_start("to");
        for (int k = 0; k < TimeoutCycles - 1; k++) begin
            step(1'b1, 4'h0, 1'b0, 1'b0);
            check($sformatf("to_wait%0d", k), 4'h1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 4'h0, 1'b0, 1'b0); check("to_fire", 4'h0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'h0, 1'b0, 1'b0); check("to_hold", 4'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b0); check("to_clear", 4'h0, 1'b0, 1'b0, 1'b0);

        reach_wait_start("race");
        for (int k = 0; k < TimeoutCycles - 1; k++) begin
            step(1'b1, 4'h0, 1'b0, 1'b0);
            check($sformatf("race_wait%0d", k), 4'h1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 4'h2, 1'b0, 1'b0); check("race_resp", 4'h1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'h0, 1'b0, 1'b0);
            check($sformatf("race_cal%0d", k), 4'h1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 4'h0, 1'b0, 1'b0); check("race_endreq", 4'h3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0); check("race_abort",  4'h0, 1'b0, 1'b0, 1'b0);
`else
        reach_wait_start("nowait");
        for (int k = 0; k < 2 * TimeoutCycles; k++) begin
            step(1'b1, 4'h0, 1'b0, 1'b0);
            check($sformatf("nowait%0d", k), 4'h1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 4'h0, 1'b0, 1'b0); check("nowait_abort", 4'h0, 1'b0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
